cache_timing_model: RTL and testbench
=====================================

# cache_timing_model

Parametrised set-associative cache timing model for the GPU memory path: it looks up each request address against a tag array and reports hit/miss one cycle later. Misses are tracked in a small MSHR pool. Each MSHR counts down a per-address programmable miss latency and then installs the line. It replaces the single-entry, fully-associative latency emulator with configurable geometry, multiple outstanding misses, miss merging and backpressure.

## Interface
- `ADDR_W`, 27, request/line address width
- `LAT_ADDR_W`, 8, latency-table index width; table is indexed by `req_addr[LAT_ADDR_W-1:0]`
- `LAT_W`, 5, latency value width
- `SETS`, 8, number of sets (power of 2); set index is `req_addr[log2(SETS)-1:0]`
- `WAYS`, 4, associativity (power of 2)
- `MSHRS`, 4, outstanding-miss entries
- `DEFAULT_LAT`, 5, initial content of every latency-table entry
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  1  lookup request
- `req_addr`  in  ADDR_W  line address
- `req_ready`  out  1  request accepted when `req_valid && req_ready`
- `lookup_valid`  out  1  lookup result valid (one cycle after acceptance)
- `lookup_hit`  out  1  tag hit, or fill bypass
- `lookup_merge`  out  1  miss to a line already pending in an MSHR
- `lookup_lat`  out  LAT_W  miss latency loaded for this lookup (0 on hit/merge)
- `fill_valid`  out  1  one-cycle pulse: line installed
- `fill_addr`  out  ADDR_W  installed line address
- `FIO_CACHE_LAT_WRITE`  in  1  latency-table write strobe
- `FIO_CACHE_MEM_ADDR`  in  LAT_ADDR_W  write index
- `FIO_CACHE_LAT_VALUE`  in  LAT_W  write data
- `stats_clear`  in  1  clear counters (only with `CTM_STATS_EN`)
- `hit_count`, `miss_count`, `merge_count`  out  32 each  counters (only with `CTM_STATS_EN`)

## Operation
- Stage 0, acceptance cycle T:
  - register address;
  - read latency table, read-first: a same-cycle write to the same index returns the old value.
- Stage 1, cycle T+1:
  - Compare against all valid ways of the set, plus the fill installing this cycle (bypass), plus all busy MSHR addresses.
  - Priority is hit > merge > miss.
  - A miss allocates the lowest free MSHR with count L = max(table value, 1).
  - `lookup_lat` = L on a miss.
- MSHR states: FREE → COUNT (load L) → DONE (count reached 0) → FREE on install.
  - Counts decrement every cycle while in COUNT.
- Install:
  - One per cycle; the lowest-index DONE MSHR wins.
  - Others stay DONE, with no further decrement.
  - Way is chosen by a per-set round-robin pointer of log2(WAYS) bits, wrapping WAYS-1 → 0.
  - Install writes the tag, sets valid, advances the pointer and frees the MSHR.
- `req_ready` = 0 when:
  - free MSHRs = 0; or
  - free MSHRs = 1 and stage 1 holds an allocating miss.
  - Same-cycle frees are not credited (conservative).
- A merged lookup allocates nothing; it completes with the existing MSHR's fill.
- Latency table contents are not affected by `reset`.

## Timing
- Reset values: `lookup_valid`, `lookup_hit`, `lookup_merge`, `fill_valid` = 0; `lookup_lat`, `fill_addr` = 0; `req_ready` = 1.
- Reset state: all tags invalid, all MSHRs FREE, round-robin pointers 0, counters 0.
- Reset asserted mid-operation: pending misses are dropped, with no fill pulse afterwards.
- Lookup result appears at T+1.
- Unarbitrated miss fill: `fill_valid` is asserted at cycle T+1+L.
- Install in cycle F: a lookup of the same line at stage 1 in cycle F reports hit (bypass). Lookups at F+1 hit from the tag array.
- FIO write at cycle W takes effect for requests accepted at W+1 or later.

## Configuration
- `CTM_STATS_EN` defined:
  - hit/miss/merge counters, incremented on the matching `lookup_*` outcome;
  - 32-bit, saturating at 0xFFFFFFFF;
  - `stats_clear` zeroes them synchronously and takes precedence over increment.
- `CTM_STATS_EN` undefined: counter ports and `stats_clear` are absent, and no counter logic is built.

## Test plan
- Write lat[0x12]=7, then request 0x12 at T → miss at T+1 with `lookup_lat`=7, `fill_valid`/`fill_addr`=0x12 at T+8; request 0x12 again → hit at +1.
- Miss to 0x40, then 0x40 again 2 cycles later → second reports `lookup_merge`=1; exactly one fill.
- Issue 5 distinct misses with MSHRS=4 and lat=20 → `req_ready` low before the 5th is accepted; it recovers after the first fill.
- Three MSHRs with equal latency reach DONE in the same cycle → fills on 3 consecutive cycles in index order.
- Fill 5 distinct lines into set 0 with WAYS=4 → the first line is evicted; a re-request of it misses.
- Assert `reset` with 2 misses pending → no fill pulses afterward; all outputs at reset values; latency table retains its values.

Source files
------------

// File: rtl/cache_timing_model_if.sv
// Request, lookup, fill and latency-write bundle for cache_timing_model.
// Counter signals are present only when CTM_STATS_EN is defined.
interface cache_timing_model_if #(
  parameter int unsigned ADDR_W     = 27,
  parameter int unsigned LAT_ADDR_W = 8,
  parameter int unsigned LAT_W      = 5
);
  logic                  req_valid;
  logic [ADDR_W-1:0]     req_addr;
  logic                  req_ready;
  logic                  lookup_valid;
  logic                  lookup_hit;
  logic                  lookup_merge;
  logic [LAT_W-1:0]      lookup_lat;
  logic                  fill_valid;
  logic [ADDR_W-1:0]     fill_addr;
  logic                  FIO_CACHE_LAT_WRITE;
  logic [LAT_ADDR_W-1:0] FIO_CACHE_MEM_ADDR;
  logic [LAT_W-1:0]      FIO_CACHE_LAT_VALUE;
`ifdef CTM_STATS_EN
  logic                  stats_clear;
  logic [31:0]           hit_count;
  logic [31:0]           miss_count;
  logic [31:0]           merge_count;

  modport slave (
    input  req_valid, req_addr, FIO_CACHE_LAT_WRITE, FIO_CACHE_MEM_ADDR, FIO_CACHE_LAT_VALUE,
           stats_clear,
    output req_ready, lookup_valid, lookup_hit, lookup_merge, lookup_lat, fill_valid, fill_addr,
           hit_count, miss_count, merge_count
  );
  modport master (
    output req_valid, req_addr, FIO_CACHE_LAT_WRITE, FIO_CACHE_MEM_ADDR, FIO_CACHE_LAT_VALUE,
           stats_clear,
    input  req_ready, lookup_valid, lookup_hit, lookup_merge, lookup_lat, fill_valid, fill_addr,
           hit_count, miss_count, merge_count
  );
`else
  modport slave (
    input  req_valid, req_addr, FIO_CACHE_LAT_WRITE, FIO_CACHE_MEM_ADDR, FIO_CACHE_LAT_VALUE,
    output req_ready, lookup_valid, lookup_hit, lookup_merge, lookup_lat, fill_valid, fill_addr
  );
  modport master (
    output req_valid, req_addr, FIO_CACHE_LAT_WRITE, FIO_CACHE_MEM_ADDR, FIO_CACHE_LAT_VALUE,
    input  req_ready, lookup_valid, lookup_hit, lookup_merge, lookup_lat, fill_valid, fill_addr
  );
`endif
endinterface

// File: rtl/cache_timing_model.sv
// Set-associative cache timing model: tag lookup, MSHR miss tracking with programmable latency.
// Optional hit/miss/merge counters are built when CTM_STATS_EN is defined.
module cache_timing_model #(
  parameter int unsigned ADDR_W      = 27,
  parameter int unsigned LAT_ADDR_W  = 8,
  parameter int unsigned LAT_W       = 5,
  parameter int unsigned SETS        = 8,
  parameter int unsigned WAYS        = 4,
  parameter int unsigned MSHRS       = 4,
  parameter int unsigned DEFAULT_LAT = 5
) (
  input  logic                clk,
  input  logic                reset,
  cache_timing_model_if.slave bus
);
  localparam int unsigned SET_W     = (SETS > 1) ? $clog2(SETS) : 1;
  localparam int unsigned WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned MIDX_W    = (MSHRS > 1) ? $clog2(MSHRS) : 1;
  localparam int unsigned MCNT_W    = $clog2(MSHRS + 1);
  localparam int unsigned LAT_DEPTH = 1 << LAT_ADDR_W;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(DEFAULT_LAT);

  typedef enum logic [1:0] {M_FREE, M_COUNT, M_DONE} mshr_state_e;

  mshr_state_e       mst_q   [MSHRS];
  mshr_state_e       mst_d   [MSHRS];
  logic [LAT_W-1:0]  mcnt_q  [MSHRS];
  logic [LAT_W-1:0]  mcnt_d  [MSHRS];
  logic [ADDR_W-1:0] maddr_q [MSHRS];
  logic [ADDR_W-1:0] maddr_d [MSHRS];

  logic [ADDR_W-1:0] tag_q   [SETS][WAYS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAY_W-1:0]  rr_q    [SETS];
  logic [LAT_W-1:0]  lat_q   [LAT_DEPTH];

  logic              s1_valid_q;
  logic [ADDR_W-1:0] s1_addr_q;
  logic [LAT_W-1:0]  s1_lat_q;

  logic              accept_c, req_ready_c;
  logic              tag_hit_c, pend_hit_c, byp_hit_c, hit_c, merge_c, miss_c;
  logic [LAT_W-1:0]  alloc_lat_c;
  logic              inst_valid_c;
  logic [MIDX_W-1:0] inst_idx_c, free_idx_c;
  logic [MCNT_W-1:0] free_cnt_c;
  logic [ADDR_W-1:0] inst_addr_c;
  logic [SET_W-1:0]  inst_set_c, s1_set_c;

  assign accept_c = bus.req_valid && req_ready_c;

  // Entries are stored XOR DEFAULT_LAT so zero-initialised storage reads back as DEFAULT_LAT.
  always_ff @(posedge clk) begin
    if (bus.FIO_CACHE_LAT_WRITE) lat_q[bus.FIO_CACHE_MEM_ADDR] <= bus.FIO_CACHE_LAT_VALUE ^ LAT_INIT;
  end

  // Stage 0: capture address and read-first latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_lat_q   <= '0;
    end else begin
      s1_valid_q <= accept_c;
      if (accept_c) begin
        s1_addr_q <= bus.req_addr;
        s1_lat_q  <= lat_q[bus.req_addr[LAT_ADDR_W-1:0]] ^ LAT_INIT;
      end
    end
  end

  // Lowest DONE entry installs; lowest FREE entry is the allocation target.
  always_comb begin
    inst_valid_c = 1'b0;
    inst_idx_c   = '0;
    free_idx_c   = '0;
    free_cnt_c   = '0;
    for (int i = int'(MSHRS) - 1; i >= 0; i--) begin
      if (mst_q[i] == M_DONE) begin
        inst_valid_c = 1'b1;
        inst_idx_c   = MIDX_W'(i);
      end
      if (mst_q[i] == M_FREE) begin
        free_idx_c = MIDX_W'(i);
        free_cnt_c = free_cnt_c + MCNT_W'(1);
      end
    end
  end

  assign inst_addr_c = maddr_q[inst_idx_c];
  assign inst_set_c  = inst_addr_c[SET_W-1:0];
  assign s1_set_c    = s1_addr_q[SET_W-1:0];

  // Stage 1 comparisons against tag array and pending misses.
  always_comb begin
    tag_hit_c  = 1'b0;
    pend_hit_c = 1'b0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (valid_q[s1_set_c][w] && (tag_q[s1_set_c][w] == s1_addr_q)) tag_hit_c = 1'b1;
    end
    for (int i = 0; i < int'(MSHRS); i++) begin
      if ((mst_q[i] != M_FREE) && (maddr_q[i] == s1_addr_q)) pend_hit_c = 1'b1;
    end
  end

  assign byp_hit_c   = inst_valid_c && (inst_addr_c == s1_addr_q);
  assign hit_c       = s1_valid_q && (tag_hit_c || byp_hit_c);
  assign merge_c     = s1_valid_q && !hit_c && pend_hit_c;
  assign miss_c      = s1_valid_q && !hit_c && !pend_hit_c;
  assign alloc_lat_c = (s1_lat_q == '0) ? LAT_W'(1) : s1_lat_q;
  assign req_ready_c = !((free_cnt_c == '0) || ((free_cnt_c == MCNT_W'(1)) && miss_c));

  // MSHR next state: count holds remaining cycles before DONE.
  always_comb begin
    for (int i = 0; i < int'(MSHRS); i++) begin
      mst_d[i]   = mst_q[i];
      mcnt_d[i]  = mcnt_q[i];
      maddr_d[i] = maddr_q[i];
    end
    for (int i = 0; i < int'(MSHRS); i++) begin
      case (mst_q[i])
        M_COUNT: begin
          mcnt_d[i] = mcnt_q[i] - LAT_W'(1);
          if (mcnt_q[i] == LAT_W'(1)) mst_d[i] = M_DONE;
        end
        M_DONE:  if (inst_valid_c && (inst_idx_c == MIDX_W'(i))) mst_d[i] = M_FREE;
        default: ;
      endcase
    end
    if (miss_c) begin
      mst_d[free_idx_c]   = (alloc_lat_c == LAT_W'(1)) ? M_DONE : M_COUNT;
      mcnt_d[free_idx_c]  = alloc_lat_c - LAT_W'(1);
      maddr_d[free_idx_c] = s1_addr_q;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(MSHRS); i++) begin
      if (reset) begin
        mst_q[i]   <= M_FREE;
        mcnt_q[i]  <= '0;
        maddr_q[i] <= '0;
      end else begin
        mst_q[i]   <= mst_d[i];
        mcnt_q[i]  <= mcnt_d[i];
        maddr_q[i] <= maddr_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && inst_valid_c) tag_q[inst_set_c][rr_q[inst_set_c]] <= inst_addr_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < int'(SETS); s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else if (inst_valid_c) begin
      valid_q[inst_set_c][rr_q[inst_set_c]] <= 1'b1;
      rr_q[inst_set_c]                      <= rr_q[inst_set_c] + WAY_W'(1);
    end
  end

  assign bus.req_ready    = req_ready_c;
  assign bus.lookup_valid = s1_valid_q;
  assign bus.lookup_hit   = hit_c;
  assign bus.lookup_merge = merge_c;
  assign bus.lookup_lat   = miss_c ? alloc_lat_c : '0;
  assign bus.fill_valid   = inst_valid_c;
  assign bus.fill_addr    = inst_valid_c ? inst_addr_c : '0;

`ifdef CTM_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q, merge_cnt_q;

  // Saturating outcome counters; clear wins over increment.
  always_ff @(posedge clk) begin
    if (reset || bus.stats_clear) begin
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      merge_cnt_q <= '0;
    end else begin
      if (hit_c && (hit_cnt_q != '1))     hit_cnt_q   <= hit_cnt_q + 32'd1;
      if (miss_c && (miss_cnt_q != '1))   miss_cnt_q  <= miss_cnt_q + 32'd1;
      if (merge_c && (merge_cnt_q != '1)) merge_cnt_q <= merge_cnt_q + 32'd1;
    end
  end

  assign bus.hit_count   = hit_cnt_q;
  assign bus.miss_count  = miss_cnt_q;
  assign bus.merge_count = merge_cnt_q;
`endif
endmodule

// File: tb/tb_cache_timing_model.sv
// Bench for cache_timing_model: directed scenarios plus random traffic against a
// transaction-level model (per-set FIFO line lists, MSHRs tracked by fill-due cycle).
module tb_cache_timing_model;
  localparam int unsigned ADDR_W      = 27;
  localparam int unsigned LAT_ADDR_W  = 8;
  localparam int unsigned LAT_W       = 5;
  localparam int unsigned SETS        = 8;
  localparam int unsigned WAYS        = 4;
  localparam int unsigned MSHRS       = 4;
  localparam int unsigned DEFAULT_LAT = 5;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  cache_timing_model_if #(.ADDR_W(ADDR_W), .LAT_ADDR_W(LAT_ADDR_W), .LAT_W(LAT_W)) ifc ();

  cache_timing_model #(
    .ADDR_W(ADDR_W), .LAT_ADDR_W(LAT_ADDR_W), .LAT_W(LAT_W), .SETS(SETS),
    .WAYS(WAYS), .MSHRS(MSHRS), .DEFAULT_LAT(DEFAULT_LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  always #5 clk = ~clk;

  // Reference state
  int                lat_m  [256];
  logic [ADDR_W-1:0] ln     [SETS][WAYS];
  int                nln    [SETS];
  logic              m_busy [MSHRS];
  logic [ADDR_W-1:0] m_addr [MSHRS];
  int                m_due  [MSHRS];
  logic              s1_v;
  logic [ADDR_W-1:0] s1_a;
  int                s1_lat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_clear();
    s1_v = 1'b0;
    for (int s = 0; s < int'(SETS); s++) nln[s] = 0;
    for (int i = 0; i < int'(MSHRS); i++) m_busy[i] = 1'b0;
  endtask

  // One cycle: compare DUT outputs with the model, advance the model, drive inputs.
  task automatic step(input logic v, input logic [ADDR_W-1:0] a, input logic w,
                      input logic [7:0] wi, input logic [4:0] wv, output logic acc);
    int fi, set, L, free_n, j;
    logic [ADDR_W-1:0] fa;
    logic hit, mrg, miss, rdy;
    fi = -1;
    for (int i = 0; i < int'(MSHRS); i++)
      if (fi < 0 && m_busy[i] && m_due[i] <= cyc) fi = i;
    fa = (fi >= 0) ? m_addr[fi] : '0;
    hit = 1'b0; mrg = 1'b0; miss = 1'b0; L = 0;
    if (s1_v) begin
      set = int'(s1_a[2:0]);
      for (int k = 0; k < nln[set]; k++) if (ln[set][k] == s1_a) hit = 1'b1;
      if (fi >= 0 && fa == s1_a) hit = 1'b1;
      if (!hit) for (int i = 0; i < int'(MSHRS); i++) if (m_busy[i] && m_addr[i] == s1_a) mrg = 1'b1;
      miss = !hit && !mrg;
      L = (s1_lat == 0) ? 1 : s1_lat;
    end
    free_n = 0;
    for (int i = 0; i < int'(MSHRS); i++) if (!m_busy[i]) free_n++;
    rdy = !((free_n == 0) || (free_n == 1 && miss));

    chk("lookup_valid", ifc.lookup_valid, s1_v);
    chk("lookup_hit",   ifc.lookup_hit,   hit);
    chk("lookup_merge", ifc.lookup_merge, mrg);
    chk("lookup_lat",   ifc.lookup_lat,   miss ? L : 0);
    chk("fill_valid",   ifc.fill_valid,   fi >= 0);
    chk("fill_addr",    ifc.fill_addr,    fa);
    chk("req_ready",    ifc.req_ready,    rdy);

    if (miss) begin
      j = -1;
      for (int i = 0; i < int'(MSHRS); i++) if (j < 0 && !m_busy[i]) j = i;
      if (j >= 0) begin
        m_busy[j] = 1'b1; m_addr[j] = s1_a; m_due[j] = cyc + L;
      end
    end
    if (fi >= 0) begin
      set = int'(fa[2:0]);
      if (nln[set] == int'(WAYS)) begin
        for (int k = 0; k < int'(WAYS) - 1; k++) ln[set][k] = ln[set][k+1];
        nln[set]--;
      end
      ln[set][nln[set]] = fa;
      nln[set]++;
      m_busy[fi] = 1'b0;
    end
    acc  = v && rdy;
    s1_v = acc;
    if (acc) begin
      s1_a   = a;
      s1_lat = lat_m[a[7:0]];
    end
    if (w) lat_m[wi] = int'(wv);

    ifc.req_valid           = v;
    ifc.req_addr            = a;
    ifc.FIO_CACHE_LAT_WRITE = w;
    ifc.FIO_CACHE_MEM_ADDR  = wi;
    ifc.FIO_CACHE_LAT_VALUE = wv;
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    logic acc;
    repeat (n) step(1'b0, '0, 1'b0, 8'h0, 5'h0, acc);
  endtask

  task automatic wr(input logic [7:0] idx, input logic [4:0] val);
    logic acc;
    step(1'b0, '0, 1'b1, idx, val, acc);
  endtask

  task automatic req(input logic [ADDR_W-1:0] a);
    logic acc;
    int   n;
    n = 0;
    do begin
      step(1'b1, a, 1'b0, 8'h0, 5'h0, acc);
      n++;
    end while (!acc && n < 200);
    chk("req_accept_timeout", acc, 1'b1);
  endtask

  task automatic rst();
    reset                   = 1'b1;
    ifc.req_valid           = 1'b0;
    ifc.req_addr            = '0;
    ifc.FIO_CACHE_LAT_WRITE = 1'b0;
    ifc.FIO_CACHE_MEM_ADDR  = '0;
    ifc.FIO_CACHE_LAT_VALUE = '0;
    @(negedge clk);
    cyc++;
    chk("rst_lookup_valid", ifc.lookup_valid, 1'b0);
    chk("rst_lookup_hit",   ifc.lookup_hit,   1'b0);
    chk("rst_lookup_merge", ifc.lookup_merge, 1'b0);
    chk("rst_lookup_lat",   ifc.lookup_lat,   0);
    chk("rst_fill_valid",   ifc.fill_valid,   1'b0);
    chk("rst_fill_addr",    ifc.fill_addr,    0);
    chk("rst_req_ready",    ifc.req_ready,    1'b1);
    @(negedge clk);
    cyc++;
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    logic              v, w, acc;
    logic [ADDR_W-1:0] a;
    logic [7:0]        wi;
    logic [4:0]        wv;
    for (int i = 0; i < 256; i++) lat_m[i] = int'(DEFAULT_LAT);
`ifdef CTM_STATS_EN
    ifc.stats_clear = 1'b0;
`endif
    model_clear();
    rst();

    // Programmed latency, fill at T+8, then a hit.
    wr(8'h12, 5'd7); idle(1); req(27'h12); idle(10); req(27'h12); idle(3);
    // Merge onto a pending miss.
    req(27'h40); idle(1); req(27'h40); idle(12);
    // Five long misses exhaust the MSHR pool.
    for (int i = 1; i <= 5; i++) wr(8'(8'h20 + i), 5'd20);
    for (int i = 1; i <= 5; i++) req(27'(8'h20 + i));
    idle(45);
    // Three entries reach DONE together.
    wr(8'h31, 5'd6); wr(8'h32, 5'd5); wr(8'h33, 5'd4);
    req(27'h31); req(27'h32); req(27'h33); idle(12);
    // Five lines into set 0 evict the oldest.
    for (int i = 1; i <= 5; i++) begin req(27'(8 * (8 + i))); idle(8); end
    req(27'h48); idle(8);
    // Reset with misses pending; table keeps its contents.
    wr(8'h71, 5'd20); wr(8'h72, 5'd20); req(27'h71); req(27'h72); idle(3);
    rst(); idle(30); req(27'h71); idle(25);
    // Latency 0 is treated as 1.
    wr(8'h05, 5'd0); req(27'h5); idle(4);

    repeat (2000) begin
      v  = ($urandom_range(0, 9) < 6);
      a  = 27'(($urandom_range(0, 5) << 3) | $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) a = a | 27'(1 << 20);
      w  = ($urandom_range(0, 15) == 0);
      wi = 8'($urandom_range(0, 47));
      wv = 5'($urandom_range(0, 12));
      step(v, a, w, wi, wv, acc);
    end
    idle(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
